sal_cmd_sched: RTL

- Per-channel command scheduler. It is the responder side of the bank-controller-to-scheduler request/grant interface.
- Each cycle it collects ACT/RD/WR/PRE/REF requests from NUM_BANKS bank controllers and grants at most one, under channel-level timing (tRRD, tCCD, tWTR, tRTW).
- The granted command is driven onto a registered DRAM command bus.

---
 rtl/sal_sched_pkg.sv | 33 +++
 rtl/sal_rr_arbiter.sv | 40 ++++
 rtl/sal_timing_cnt.sv | 38 +++
 rtl/sal_cmd_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sal_sched_pkg.sv
// sal_sched_pkg: shared definitions for the per-channel command scheduler.
//   cmd_t          - DRAM command bus encoding driven on cmd_o
//   cls_t          - request classes; a lower encoding means a higher priority
//   NUM_CLS        - number of request classes
//   t_load_val()   - converts a minimum spacing t into a down-counter load value
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  // Class priority: REF > RD/WR (CAS) > PRE > ACT.
  typedef enum logic [1:0] {
    CLS_REF = 2'd0,
    CLS_CAS = 2'd1,
    CLS_PRE = 2'd2,
    CLS_ACT = 2'd3
  } cls_t;

  localparam int NUM_CLS = 4;

  // A grant at cycle c must allow the next one at c+t, so the counter holds
  // t-1 after the grant edge; t of 0 or 1 means no blocking at all.
  function automatic logic [31:0] t_load_val(input logic [31:0] t);
    return (t >= 32'd1) ? (t - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/sal_rr_arbiter.sv
// sal_rr_arbiter: combinational round-robin arbiter.
//   req_i  - request vector
//   ptr_i  - index that has highest priority this cycle
//   gnt_o  - one-hot grant (all zero when no request)
//   idx_o  - index of the granted requester
//   vld_o  - some request was granted
module sal_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] cand;
  logic          found;

  // N is a power of two, so ptr+i wraps naturally in IW bits.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_i + IW'(i);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (found) begin
      gnt_o[idx_o] = 1'b1;
    end
    vld_o = found;
  end

endmodule

// File: rtl/sal_timing_cnt.sv
// sal_timing_cnt: generic clamped down-counter used as a channel timing gate.
//   clk, rst_n    - clock, asynchronous active-low reset (counter -> RST_VAL)
//   load_i        - load load_val_i this cycle (takes precedence over decrement)
//   load_val_i    - value to load
//   zero_o        - counter currently equals zero (gate open)
module sal_timing_cnt #(
  parameter int         W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: per-channel DRAM command scheduler (responder side of the
// bank-controller request/grant interface).
//   clk, rst_n            - clock, asynchronous active-low reset
//   *_req_i               - per-bank ACT/RD/WR/PRE/REF requests
//   ra_i / ca_i           - per-bank row/column address, bank b at [b*W +: W]
//   t_rrd/ccd/wtr/rtw_i   - minimum command spacing in cycles
//   *_gnt_o               - per-bank combinational grants, at most one bit set
//   cmd_o/cmd_ba_o/cmd_addr_o - registered command bus (one cycle after grant)
// Optional macro SAL_SCHED_PERF_CNT_EN adds 32-bit act/cas/pre/ref command
// counters (act_cnt_o, cas_cnt_o, pre_cnt_o, ref_cnt_o).
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter  int NUM_BANKS = 4,
  parameter  int RA_W      = 14,
  parameter  int CA_W      = 10,
  parameter  int TW        = 4,
  localparam int BA_W      = $clog2(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_BANKS-1:0]      act_req_i,
  input  logic [NUM_BANKS-1:0]      rd_req_i,
  input  logic [NUM_BANKS-1:0]      wr_req_i,
  input  logic [NUM_BANKS-1:0]      pre_req_i,
  input  logic [NUM_BANKS-1:0]      ref_req_i,
  input  logic [NUM_BANKS*RA_W-1:0] ra_i,
  input  logic [NUM_BANKS*CA_W-1:0] ca_i,
  input  logic [TW-1:0]             t_rrd_i,
  input  logic [TW-1:0]             t_ccd_i,
  input  logic [TW-1:0]             t_wtr_i,
  input  logic [TW-1:0]             t_rtw_i,
  output logic [NUM_BANKS-1:0]      act_gnt_o,
  output logic [NUM_BANKS-1:0]      rd_gnt_o,
  output logic [NUM_BANKS-1:0]      wr_gnt_o,
  output logic [NUM_BANKS-1:0]      pre_gnt_o,
  output logic [NUM_BANKS-1:0]      ref_gnt_o,
`ifdef SAL_SCHED_PERF_CNT_EN
  output logic [31:0]               act_cnt_o,
  output logic [31:0]               cas_cnt_o,
  output logic [31:0]               pre_cnt_o,
  output logic [31:0]               ref_cnt_o,
`endif
  output logic [2:0]                cmd_o,
  output logic [BA_W-1:0]           cmd_ba_o,
  output logic [RA_W-1:0]           cmd_addr_o
);

  logic [BA_W-1:0]      rr_ptr_q, rr_ptr_d;
  cmd_t                 cmd_q, cmd_d;
  logic [BA_W-1:0]      ba_q, ba_d;
  logic [RA_W-1:0]      addr_q, addr_d;

  logic                 rrd_zero, ccd_zero, wtr_zero, rtw_zero;
  logic [NUM_BANKS-1:0] rd_el, wr_el;

  logic [NUM_BANKS-1:0] cls_req [NUM_CLS];
  logic [NUM_BANKS-1:0] cls_gnt [NUM_CLS];
  logic [BA_W-1:0]      cls_idx [NUM_CLS];
  logic [NUM_CLS-1:0]   cls_vld;

  cls_t                 sel_cls;
  logic                 sel_vld;

  // RD is closed by tCCD and tWTR, WR by tCCD and tRTW; REF/PRE are ungated.
  assign rd_el = rd_req_i & {NUM_BANKS{ccd_zero & wtr_zero}};
  assign wr_el = wr_req_i & {NUM_BANKS{ccd_zero & rtw_zero}};

  assign cls_req[CLS_REF] = ref_req_i;
  assign cls_req[CLS_CAS] = rd_el | wr_el;
  assign cls_req[CLS_PRE] = pre_req_i;
  assign cls_req[CLS_ACT] = act_req_i & {NUM_BANKS{rrd_zero}};

  for (genvar c = 0; c < NUM_CLS; c++) begin : g_arb
    sal_rr_arbiter #(.N(NUM_BANKS)) u_arb (
      .req_i (cls_req[c]),
      .ptr_i (rr_ptr_q),
      .gnt_o (cls_gnt[c]),
      .idx_o (cls_idx[c]),
      .vld_o (cls_vld[c])
    );
  end

  // Pick the highest-priority class with an eligible request.
  always_comb begin
    sel_vld = 1'b0;
    sel_cls = CLS_REF;
    for (int c = 0; c < NUM_CLS; c++) begin
      if (!sel_vld && cls_vld[c]) begin
        sel_vld = 1'b1;
        sel_cls = cls_t'(c);
      end
    end
  end

  // Grants are suppressed during reset. Within CAS, RD wins when it is eligible.
  always_comb begin
    act_gnt_o = '0;
    rd_gnt_o  = '0;
    wr_gnt_o  = '0;
    pre_gnt_o = '0;
    ref_gnt_o = '0;
    cmd_d     = CMD_NOP;
    ba_d      = '0;
    addr_d    = '0;
    if (rst_n && sel_vld) begin
      ba_d = cls_idx[sel_cls];
      unique case (sel_cls)
        CLS_REF: begin
          ref_gnt_o = cls_gnt[CLS_REF];
          cmd_d     = CMD_REF;
        end
        CLS_CAS: begin
          addr_d = RA_W'(ca_i[int'(ba_d)*CA_W +: CA_W]);
          if (rd_el[ba_d]) begin
            rd_gnt_o = cls_gnt[CLS_CAS];
            cmd_d    = CMD_RD;
          end else begin
            wr_gnt_o = cls_gnt[CLS_CAS];
            cmd_d    = CMD_WR;
          end
        end
        CLS_PRE: begin
          pre_gnt_o = cls_gnt[CLS_PRE];
          cmd_d     = CMD_PRE;
        end
        CLS_ACT: begin
          act_gnt_o = cls_gnt[CLS_ACT];
          cmd_d     = CMD_ACT;
          addr_d    = ra_i[int'(ba_d)*RA_W +: RA_W];
        end
        default: ;
      endcase
    end
  end

  assign rr_ptr_d = (cmd_d != CMD_NOP) ? (ba_d + BA_W'(1)) : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      cmd_q    <= CMD_NOP;
      ba_q     <= '0;
      addr_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cmd_q    <= cmd_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
    end
  end

  assign cmd_o      = cmd_q;
  assign cmd_ba_o   = ba_q;
  assign cmd_addr_o = addr_q;

  // Timing values are captured only at load; a running count ignores changes.
  sal_timing_cnt #(.W(TW)) u_rrd (
    .clk, .rst_n,
    .load_i     (cmd_d == CMD_ACT),
    .load_val_i (TW'(t_load_val(32'(t_rrd_i)))),
    .zero_o     (rrd_zero)
  );

  sal_timing_cnt #(.W(TW)) u_ccd (
    .clk, .rst_n,
    .load_i     ((cmd_d == CMD_RD) || (cmd_d == CMD_WR)),
    .load_val_i (TW'(t_load_val(32'(t_ccd_i)))),
    .zero_o     (ccd_zero)
  );

  sal_timing_cnt #(.W(TW)) u_wtr (
    .clk, .rst_n,
    .load_i     (cmd_d == CMD_WR),
    .load_val_i (TW'(t_load_val(32'(t_wtr_i)))),
    .zero_o     (wtr_zero)
  );

  sal_timing_cnt #(.W(TW)) u_rtw (
    .clk, .rst_n,
    .load_i     (cmd_d == CMD_RD),
    .load_val_i (TW'(t_load_val(32'(t_rtw_i)))),
    .zero_o     (rtw_zero)
  );

`ifdef SAL_SCHED_PERF_CNT_EN
  logic [31:0] act_cnt_q, act_cnt_d;
  logic [31:0] cas_cnt_q, cas_cnt_d;
  logic [31:0] pre_cnt_q, pre_cnt_d;
  logic [31:0] ref_cnt_q, ref_cnt_d;

  // Counts follow the command bus, so they trail cmd_o by one cycle.
  always_comb begin
    act_cnt_d = act_cnt_q + 32'((cmd_q == CMD_ACT));
    cas_cnt_d = cas_cnt_q + 32'((cmd_q == CMD_RD) || (cmd_q == CMD_WR));
    pre_cnt_d = pre_cnt_q + 32'((cmd_q == CMD_PRE));
    ref_cnt_d = ref_cnt_q + 32'((cmd_q == CMD_REF));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cnt_q <= '0;
      cas_cnt_q <= '0;
      pre_cnt_q <= '0;
      ref_cnt_q <= '0;
    end else begin
      act_cnt_q <= act_cnt_d;
      cas_cnt_q <= cas_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  assign act_cnt_o = act_cnt_q;
  assign cas_cnt_o = cas_cnt_q;
  assign pre_cnt_o = pre_cnt_q;
  assign ref_cnt_o = ref_cnt_q;
`endif

  // A bank must never ask for RD and WR together; RD would silently win.
  rd_wr_conflict_a : assert property (@(posedge clk) disable iff (!rst_n)
    ((rd_req_i & wr_req_i) == '0));

endmodule
